// File: rtl/acp_pkg.sv
// Shared constants and types for the ACP frame sequencer.
//   - default step counts (CPU cycles) for the 4- and 5-step sequences
//   - $4017 / $4015 bit positions
//   - delay-FSM state encoding and write-to-reset delays
//   - decoded step-event bundle produced by acp_frame_step_decode
package acp_pkg;

   localparam int unsigned STEP1 = 7457;
   localparam int unsigned STEP2 = 14913;
   localparam int unsigned STEP3 = 22371;
   localparam int unsigned STEP4 = 29829;
   localparam int unsigned STEP5 = 37281;

   localparam int FC_MODE_BIT        = 7;
   localparam int FC_INH_BIT         = 6;
   localparam int STAT_FRAME_IRQ_BIT = 6;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } fs_state_e;

   // A $4017 write lands 3 or 4 CPU cycles later depending on APU parity.
   localparam logic [2:0] DLY_EVEN = 3'd3;
   localparam logic [2:0] DLY_ODD  = 3'd4;

   typedef struct packed {
      logic q;
      logic h;
      logic irq_set;
      logic last;
   } step_evt_t;

endpackage

// File: rtl/acp_frame_sequencer_if.sv
// Bus between the ACP MMIO register block and the frame sequencer.
//   i_cpu_ce        CPU-cycle enable
//   i_fc_we         $4017 write strobe, i_fc_data its data byte
//   i_status_rd     $4015 read strobe
//   o_quarter_frame / o_half_frame   one-clock frame pulses
//   o_frame_irq_flag, o_irq          $4015 bit 6 and the IRQ request
//   o_mode, o_apu_phase              current mode bit and APU parity
interface acp_frame_sequencer_if;

   logic       i_cpu_ce;
   logic       i_fc_we;
   logic [7:0] i_fc_data;
   logic       i_status_rd;
   logic       o_quarter_frame;
   logic       o_half_frame;
   logic       o_frame_irq_flag;
   logic       o_irq;
   logic       o_mode;
   logic       o_apu_phase;

   modport master (
      output i_cpu_ce, i_fc_we, i_fc_data, i_status_rd,
      input  o_quarter_frame, o_half_frame, o_frame_irq_flag, o_irq, o_mode, o_apu_phase
   );

   modport slave (
      input  i_cpu_ce, i_fc_we, i_fc_data, i_status_rd,
      output o_quarter_frame, o_half_frame, o_frame_irq_flag, o_irq, o_mode, o_apu_phase
   );

endinterface

// File: rtl/acp_frame_step_decode.sv
// Combinational step decoder: maps the frame cycle counter to step events.
//   count    current cycle count
//   mode     0 = 4-step, 1 = 5-step
//   wrapped  count reached 0 through a natural wrap (not a $4017 reset)
//   evt      {q, h, irq_set, last}; last marks the mode's final step
module acp_frame_step_decode
   import acp_pkg::*;
#(
   parameter int unsigned STEP1 = acp_pkg::STEP1,
   parameter int unsigned STEP2 = acp_pkg::STEP2,
   parameter int unsigned STEP3 = acp_pkg::STEP3,
   parameter int unsigned STEP4 = acp_pkg::STEP4,
   parameter int unsigned STEP5 = acp_pkg::STEP5,
   parameter int unsigned CNT_W = 16
) (
   input  logic [CNT_W-1:0] count,
   input  logic             mode,
   input  logic             wrapped,
   output step_evt_t        evt
);

   localparam logic [CNT_W-1:0] S1   = CNT_W'(STEP1);
   localparam logic [CNT_W-1:0] S2   = CNT_W'(STEP2);
   localparam logic [CNT_W-1:0] S3   = CNT_W'(STEP3);
   localparam logic [CNT_W-1:0] S4   = CNT_W'(STEP4);
   localparam logic [CNT_W-1:0] S4M1 = CNT_W'(STEP4 - 1);
   localparam logic [CNT_W-1:0] S5   = CNT_W'(STEP5);

   logic at_final;

   always_comb begin
      at_final    = mode ? (count == S5) : (count == S4);
      evt.last    = at_final;
      evt.q       = (count == S1) || (count == S2) || (count == S3) || at_final;
      evt.h       = (count == S2) || at_final;
      evt.irq_set = !mode && ((count == S4M1) || (count == S4) ||
                              ((count == '0) && wrapped));
   end

endmodule

// File: rtl/acp_frame_sequencer.sv
// ACP frame-counter scheduler.
//   i_clk_cpu  CPU clock
//   i_reset    synchronous active-high reset
//   bus        acp_frame_sequencer_if.slave: strobes in, frame pulses/IRQ/status out
//
// state | meaning
// RUN   | counting, no $4017 write outstanding
// PEND  | $4017 write waiting for its 3/4-cycle delay; counter keeps running
module acp_frame_sequencer
   import acp_pkg::*;
#(
   parameter int unsigned STEP1 = acp_pkg::STEP1,
   parameter int unsigned STEP2 = acp_pkg::STEP2,
   parameter int unsigned STEP3 = acp_pkg::STEP3,
   parameter int unsigned STEP4 = acp_pkg::STEP4,
   parameter int unsigned STEP5 = acp_pkg::STEP5,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  i_clk_cpu,
   input  logic                  i_reset,
   acp_frame_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);

   fs_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       delay_q, delay_d;
   logic             mode_q, mode_d;
   logic             inh_q, inh_d;
   logic             flag_q, flag_d;
   logic             phase_q, phase_d;
   logic             wrapped_q, wrapped_d;
   logic             quarter_q, quarter_d;
   logic             half_q, half_d;
   logic             over_4step;
   logic             unused_fc_bits;
   step_evt_t        evt;

   acp_frame_step_decode #(
      .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3),
      .STEP4(STEP4), .STEP5(STEP5), .CNT_W(CNT_W)
   ) u_decode (
      .count   (count_q),
      .mode    (mode_q),
      .wrapped (wrapped_q),
      .evt     (evt)
   );

   // Left above STEP4 by a 5-step -> 4-step switch; wrap silently.
   assign over_4step     = !mode_q && (count_q > S4);
   assign unused_fc_bits = ^bus.i_fc_data[5:0];

   always_ff @(posedge i_clk_cpu) begin
      if (i_reset) begin
         state_q   <= ST_RUN;
         count_q   <= '0;
         delay_q   <= '0;
         mode_q    <= 1'b0;
         inh_q     <= 1'b0;
         flag_q    <= 1'b0;
         phase_q   <= 1'b0;
         wrapped_q <= 1'b0;
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         delay_q   <= delay_d;
         mode_q    <= mode_d;
         inh_q     <= inh_d;
         flag_q    <= flag_d;
         phase_q   <= phase_d;
         wrapped_q <= wrapped_d;
         quarter_q <= quarter_d;
         half_q    <= half_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      delay_d   = delay_q;
      mode_d    = mode_q;
      inh_d     = inh_q;
      flag_d    = flag_q;
      phase_d   = phase_q;
      wrapped_d = wrapped_q;
      quarter_d = 1'b0;
      half_d    = 1'b0;

      if (bus.i_cpu_ce) begin
         phase_d   = !phase_q;
         quarter_d = evt.q;
         half_d    = evt.h;
         wrapped_d = evt.last;
         if (evt.last || over_4step) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end

         // A set event beats a coincident $4015 read.
         if (evt.irq_set && !inh_q) begin
            flag_d = 1'b1;
         end else if (bus.i_status_rd) begin
            flag_d = 1'b0;
         end

         if (bus.i_fc_we) begin
            mode_d  = bus.i_fc_data[FC_MODE_BIT];
            inh_d   = bus.i_fc_data[FC_INH_BIT];
            if (bus.i_fc_data[FC_INH_BIT]) begin
               flag_d = 1'b0;
            end
            state_d = ST_PEND;
            delay_d = phase_q ? DLY_ODD : DLY_EVEN;
         end else if (state_q == ST_PEND) begin
            delay_d = delay_q - 3'd1;
            if (delay_q == 3'd1) begin
               state_d   = ST_RUN;
               count_d   = '0;
               wrapped_d = 1'b0;
               if (mode_q) begin
                  quarter_d = 1'b1;
                  half_d    = 1'b1;
               end
            end
         end
      end
   end

   assign bus.o_quarter_frame  = quarter_q;
   assign bus.o_half_frame     = half_q;
   assign bus.o_frame_irq_flag = flag_q;
   assign bus.o_irq            = flag_q & ~inh_q;
   assign bus.o_mode           = mode_q;
   assign bus.o_apu_phase      = phase_q;

endmodule

// File: doc/acp_frame_sequencer.md
Name: acp_frame_sequencer

Overview:
- Frame-counter scheduler for the Audio Co-Processor. It is configured by CPU writes to $4017 and acknowledged by CPU reads of $4015.
- Drives quarter-frame and half-frame clock pulses to the envelope, linear-counter, length-counter and sweep units.
- Generates the frame interrupt and the $4015 bit-6 status flag.
- Sits beside the ACP MMIO register block, which forwards decoded $4017 write and $4015 read strobes to it.

Parameters:
- STEP1, 7457, CPU-cycle count of step 1 (quarter frame).
- STEP2, 14913, count of step 2 (quarter + half frame).
- STEP3, 22371, count of step 3 (quarter frame).
- STEP4, 29829, count of step 4. 4-step mode: quarter + half + IRQ. 5-step mode: no event.
- STEP5, 37281, count of step 5, 5-step mode only (quarter + half).
- CNT_W, 16, width of the cycle counter; must hold STEP5.

Ports:
- i_clk_cpu  in  1  CPU clock.
- i_reset  in  1  synchronous reset, active-high.
- i_cpu_ce  in  1  CPU-cycle enable; all sequencing advances only when high.
- i_fc_we  in  1  $4017 write strobe (qualified by i_cpu_ce).
- i_fc_data  in  8  $4017 write data: bit7 = mode (1 = 5-step), bit6 = IRQ inhibit.
- i_status_rd  in  1  $4015 read strobe (qualified by i_cpu_ce).
- o_quarter_frame  out  1  one-clock quarter-frame pulse.
- o_half_frame  out  1  one-clock half-frame pulse.
- o_frame_irq_flag  out  1  frame IRQ flag, for $4015 bit 6.
- o_irq  out  1  frame IRQ request = flag AND NOT inhibit.
- o_mode  out  1  current mode bit.
- o_apu_phase  out  1  APU cycle parity; toggles every enabled CPU cycle.

Behaviour:
- **Reset:** counter=0, mode=0, inhibit=0, flag=0, phase=0, state=RUN, delay=0. All outputs are 0 the cycle after reset. Reset mid-delay cancels the pending write.
- **Enable gating:** the counter, phase and delay change only on cycles with i_cpu_ce=1. Pulse outputs are registered, last exactly one i_clk_cpu cycle, and are never asserted on a cycle following i_cpu_ce=0.
- **States:** RUN (counting) and PEND (a $4017 write is waiting to take effect). The counter keeps counting in PEND.
- **4-step counter (mode=0):** counts 0..STEP4, then wraps to 0.
  - Q pulse at STEP1, STEP3.
  - Q+H pulses at STEP2, STEP4.
  - Flag is set at STEP4-1 and STEP4, and at count 0 when 0 was reached by wrap.
- **5-step counter (mode=1):** counts 0..STEP5, then wraps to 0.
  - Q at STEP1, STEP3.
  - Q+H at STEP2, STEP5.
  - No IRQ events.
- **Pulse timing:** a pulse is asserted on the clock edge after the enabled cycle in which the counter equals the step value (1-cycle latency).
- **$4017 write:**
  - Mode and inhibit registers update immediately on the write cycle.
  - If bit6=1, the flag clears on the same edge.
  - State goes to PEND with delay = 3 if o_apu_phase=0 at the write, or 4 if phase=1.
  - The delay decrements per enabled cycle. On the enabled cycle where it reaches 0: counter←0, state←RUN, and if mode=1 an immediate Q+H pulse pair is issued.
  - A counter reset caused by a write does not count as a wrap (no IRQ set at 0).
- **Write while PEND:** restarts the delay from the new write's phase. The latest data wins.
- **$4015 read:** the flag clears on the edge after the read cycle. The read itself sees the pre-clear value, because the flag is registered.
- **Simultaneous events:**
  - A flag-set event in the same cycle as a $4015 read: set wins, flag stays 1.
  - A flag-set event in the same cycle as a write with bit6=1: inhibit wins, flag 0.
  - While inhibit=1, set events are ignored.
- **Counter protection:** the counter never exceeds the mode's final step. A mode change from 1 to 0 while the counter is above STEP4 forces wrap to 0 on the next enabled cycle, with no IRQ.
- **Width:** all compares are unsigned CNT_W bits. No other arithmetic.

Decomposition:
- **Shared package acp_pkg:**
  - step constants STEP1..STEP5;
  - $4017 bit positions (FC_MODE_BIT=7, FC_INH_BIT=6);
  - $4015 flag position (STAT_FRAME_IRQ_BIT=6);
  - state encoding {RUN, PEND};
  - delay constants 3 and 4.
- **Sub-module acp_frame_step_decode:** combinational. Maps (counter, mode, wrapped) to {q, h, irq_set, last}. It is reused by the DMC/length-counter testbench models. The counter, delay FSM and flag stay in the top module.

Test Plan:
- **4-step run:** reset, then i_cpu_ce=1 continuously → Q at counts 7457/14913/22371/29829 and H at 14913/29829. Flag rises after count 29828. o_irq=1. Count returns to 0 after 29829.
- **5-step write:** write $4017=0x80 with phase=0 → after 3 enabled cycles, counter=0 and Q+H pulse together. Next Q at 7457, H at 37281, flag never set.
- **Odd-phase delay:** write 0x00 with phase=1 → counter reset occurs 4 enabled cycles later, no Q/H at reset.
- **Inhibit:** with flag=1, write 0x40 → flag=0 and o_irq=0 the next cycle. Run through count 29829 → flag stays 0.
- **Status read:** flag=1, pulse i_status_rd → flag=0 the next cycle. A read coincident with count 29829 → flag remains 1.
- **Gating/reset:** hold i_cpu_ce=0 for 100 cycles → counter frozen, no pulses. Assert i_reset during PEND → all outputs 0, the pending write is discarded, and counting restarts from 0 in 4-step mode.
